// File: rtl/battle_turn_ctrl.sv
// Two-player turn sequencer: conditions the attack/new-game keys, samples the
// GARO random word, applies saturating damage and tracks the winner.
module battle_turn_ctrl #(
   parameter int W          = 4,
   parameter int HP_INIT    = 9,
   parameter int DMG        = 3,
   parameter int HIT_THRESH = 7,
   parameter int SETTLE     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_attack_n,
   input  logic         key_new_n,
   input  logic [W-1:0] rand_in,
   output logic         rng_run,
   output logic [W-1:0] hp_p1,
   output logic [W-1:0] hp_p2,
   output logic         turn,
   output logic         hit,
   output logic         busy,
   output logic         game_over,
   output logic         winner
);

   localparam logic [W-1:0] HP_INIT_V   = W'(HP_INIT);
   localparam logic [W-1:0] DMG_V       = W'(DMG);
   localparam logic [W-1:0] THRESH_V    = W'(HIT_THRESH);
   localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_RESOLVE,
      S_CHECK,
      S_OVER
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [W-1:0]   sample_q, sample_d;
   logic [W-1:0]   hp_p1_q, hp_p1_d;
   logic [W-1:0]   hp_p2_q, hp_p2_d;
   logic           turn_q, turn_d;
   logic           hit_q, hit_d;
   logic           winner_q, winner_d;

   logic           atk_s1_q, atk_s2_q, atk_prev_q;
   logic           new_s1_q, new_s2_q, new_prev_q;
   logic           atk_pulse, new_pulse;
   logic [W-1:0]   def_hp;

   function automatic logic [W-1:0] sat_sub(input logic [W-1:0] hp);
      return (hp >= DMG_V) ? (hp - DMG_V) : '0;
   endfunction

   // Keys are released-high, so the synchronizers come out of reset at 1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         atk_s1_q   <= 1'b1;
         atk_s2_q   <= 1'b1;
         atk_prev_q <= 1'b1;
         new_s1_q   <= 1'b1;
         new_s2_q   <= 1'b1;
         new_prev_q <= 1'b1;
      end else begin
         atk_s1_q   <= key_attack_n;
         atk_s2_q   <= atk_s1_q;
         atk_prev_q <= atk_s2_q;
         new_s1_q   <= key_new_n;
         new_s2_q   <= new_s1_q;
         new_prev_q <= new_s2_q;
      end
   end

   assign atk_pulse = atk_prev_q & ~atk_s2_q;
   assign new_pulse = new_prev_q & ~new_s2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sample_q <= '0;
         hp_p1_q  <= HP_INIT_V;
         hp_p2_q  <= HP_INIT_V;
         turn_q   <= 1'b0;
         hit_q    <= 1'b0;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         hp_p1_q  <= hp_p1_d;
         hp_p2_q  <= hp_p2_d;
         turn_q   <= turn_d;
         hit_q    <= hit_d;
         winner_q <= winner_d;
      end
   end

   assign def_hp = turn_q ? hp_p1_q : hp_p2_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sample_d = sample_q;
      hp_p1_d  = hp_p1_q;
      hp_p2_d  = hp_p2_q;
      turn_d   = turn_q;
      hit_d    = hit_q;
      winner_d = winner_q;
      unique case (state_q)
         S_IDLE: begin
            // New game takes priority over a simultaneous attack
            if (new_pulse) begin
               hp_p1_d = HP_INIT_V;
               hp_p2_d = HP_INIT_V;
               turn_d  = 1'b0;
               hit_d   = 1'b0;
            end else if (atk_pulse) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == SETTLE_LAST) begin
               sample_d = rand_in;
               state_d  = S_RESOLVE;
            end
         end
         S_RESOLVE: begin
            hit_d = (sample_q > THRESH_V);
            if (sample_q > THRESH_V) begin
               if (turn_q) hp_p1_d = sat_sub(hp_p1_q);
               else        hp_p2_d = sat_sub(hp_p2_q);
            end
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (def_hp == '0) begin
               winner_d = turn_q;
               state_d  = S_OVER;
            end else begin
               turn_d  = ~turn_q;
               state_d = S_IDLE;
            end
         end
         S_OVER: begin
            if (new_pulse) begin
               hp_p1_d  = HP_INIT_V;
               hp_p2_d  = HP_INIT_V;
               turn_d   = 1'b0;
               hit_d    = 1'b0;
               winner_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_SAMPLE) || (state_q == S_RESOLVE) || (state_q == S_CHECK);
   assign game_over = (state_q == S_OVER);
   assign rng_run   = (state_q != S_OVER);
   assign hp_p1     = hp_p1_q;
   assign hp_p2     = hp_p2_q;
   assign turn      = turn_q;
   assign hit       = hit_q;
   assign winner    = winner_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl: default instance plus an HP_INIT=5 instance
// for the saturation and dropped-press cases.
module tb_battle_turn_ctrl;

   logic       clk;
   logic       reset_a, reset_b;
   logic       key_attack_n, key_new_n;
   logic [3:0] rand_in;

   logic       a_rng_run, a_turn, a_hit, a_busy, a_game_over, a_winner;
   logic [3:0] a_hp_p1, a_hp_p2;
   logic       b_rng_run, b_turn, b_hit, b_busy, b_game_over, b_winner;
   logic [3:0] b_hp_p1, b_hp_p2;

   int n_chk  = 0;
   int n_pass = 0;

   battle_turn_ctrl dut_a (
      .clk(clk), .reset(reset_a), .key_attack_n(key_attack_n), .key_new_n(key_new_n),
      .rand_in(rand_in), .rng_run(a_rng_run), .hp_p1(a_hp_p1), .hp_p2(a_hp_p2),
      .turn(a_turn), .hit(a_hit), .busy(a_busy), .game_over(a_game_over), .winner(a_winner)
   );

   battle_turn_ctrl #(.W(4), .HP_INIT(5), .DMG(3), .HIT_THRESH(7), .SETTLE(4)) dut_b (
      .clk(clk), .reset(reset_b), .key_attack_n(key_attack_n), .key_new_n(key_new_n),
      .rand_in(rand_in), .rng_run(b_rng_run), .hp_p1(b_hp_p1), .hp_p2(b_hp_p2),
      .turn(b_turn), .hit(b_hit), .busy(b_busy), .game_over(b_game_over), .winner(b_winner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Full attack: press, wait through SETTLE+2 busy cycles, release, let sync settle
   task automatic press_atk(input logic [3:0] rnd);
      @(negedge clk);
      rand_in      = rnd;
      key_attack_n = 1'b0;
      repeat (8) @(posedge clk);
      #1 key_attack_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic press_new();
      @(negedge clk);
      key_new_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 key_new_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_a      = 1'b0;
      reset_b      = 1'b0;
      key_attack_n = 1'b1;
      key_new_n    = 1'b1;
      rand_in      = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_a = 1'b1;
      @(posedge clk) #1;
      chk("rst_hp1", a_hp_p1, 9);
      chk("rst_hp2", a_hp_p2, 9);
      chk("rst_turn", a_turn, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_over", a_game_over, 0);
      chk("rst_rng", a_rng_run, 1);
      chk("rst_hit", a_hit, 0);

      // Detailed timing of one hit, key low before edge k
      @(negedge clk);
      rand_in      = 4'd8;
      key_attack_n = 1'b0;
      @(posedge clk);
      @(posedge clk) #1 chk("t_busy_k1", a_busy, 0);
      @(posedge clk) #1 chk("t_busy_k2", a_busy, 1);
      repeat (4) @(posedge clk);
      #1 chk("t_hp2_k6", a_hp_p2, 9);
      chk("t_busy_k6", a_busy, 1);
      @(posedge clk) #1 chk("t_hp2_k7", a_hp_p2, 6);
      chk("t_hit_k7", a_hit, 1);
      chk("t_turn_k7", a_turn, 0);
      chk("t_busy_k7", a_busy, 1);
      @(posedge clk) #1 chk("t_turn_k8", a_turn, 1);
      chk("t_busy_k8", a_busy, 0);
      key_attack_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Threshold boundary: 7 is a miss
      press_new();
      chk("ng_hp2", a_hp_p2, 9);
      chk("ng_turn", a_turn, 0);
      press_atk(4'd7);
      chk("th_hit", a_hit, 0);
      chk("th_hp1", a_hp_p1, 9);
      chk("th_hp2", a_hp_p2, 9);
      chk("th_turn", a_turn, 1);
      press_new();
      chk("ng2_turn", a_turn, 0);

      // P1 always hits, P2 always misses
      press_atk(4'd15);
      chk("g1_hp2", a_hp_p2, 6);
      press_atk(4'd0);
      chk("g1_hit", a_hit, 0);
      chk("g1_hp1", a_hp_p1, 9);
      press_atk(4'd15);
      chk("g2_hp2", a_hp_p2, 3);
      press_atk(4'd0);
      press_atk(4'd15);
      chk("g3_hp2", a_hp_p2, 0);
      chk("g3_hp1", a_hp_p1, 9);
      chk("g3_over", a_game_over, 1);
      chk("g3_winner", a_winner, 0);
      chk("g3_rng", a_rng_run, 0);
      chk("g3_busy", a_busy, 0);
      press_atk(4'd15);
      chk("ov_over", a_game_over, 1);
      chk("ov_busy", a_busy, 0);
      chk("ov_hp1", a_hp_p1, 9);
      press_new();
      chk("ov_ng_hp1", a_hp_p1, 9);
      chk("ov_ng_hp2", a_hp_p2, 9);
      chk("ov_ng_turn", a_turn, 0);
      chk("ov_ng_over", a_game_over, 0);
      chk("ov_ng_rng", a_rng_run, 1);
      chk("ov_ng_hit", a_hit, 0);

      // Simultaneous attack + new game in IDLE: reload only
      press_atk(4'd15);
      chk("sim_pre_hp2", a_hp_p2, 6);
      @(negedge clk);
      key_attack_n = 1'b0;
      key_new_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("sim_busy", a_busy, 0);
      chk("sim_hp2", a_hp_p2, 9);
      chk("sim_turn", a_turn, 0);
      key_attack_n = 1'b1;
      key_new_n    = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("sim_hp2_late", a_hp_p2, 9);
      chk("sim_turn_late", a_turn, 0);

      // Reset during SAMPLE aborts the turn
      @(negedge clk);
      rand_in      = 4'd15;
      key_attack_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("ra_busy_pre", a_busy, 1);
      key_attack_n = 1'b1;
      @(negedge clk) reset_a = 1'b0;
      #1 chk("ra_busy_async", a_busy, 0);
      repeat (2) @(negedge clk);
      reset_a = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("ra_busy", a_busy, 0);
      chk("ra_hp1", a_hp_p1, 9);
      chk("ra_hp2", a_hp_p2, 9);
      chk("ra_turn", a_turn, 0);

      // Second instance: HP_INIT=5, saturating damage, dropped press
      @(negedge clk) reset_b = 1'b1;
      @(posedge clk) #1 chk("b_rst_hp2", b_hp_p2, 5);
      @(negedge clk);
      rand_in      = 4'd15;
      key_attack_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("b_busy", b_busy, 1);
      @(negedge clk) key_attack_n = 1'b1;
      @(negedge clk) key_attack_n = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("b_hp2_a", b_hp_p2, 2);
      chk("b_turn_a", b_turn, 1);
      chk("b_busy_a", b_busy, 0);
      key_attack_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("b_drop_busy", b_busy, 0);
      chk("b_drop_hp1", b_hp_p1, 5);
      chk("b_drop_turn", b_turn, 1);
      press_atk(4'd15);
      chk("b_hp1_b", b_hp_p1, 2);
      chk("b_turn_b", b_turn, 0);
      press_atk(4'd15);
      chk("b_sat_hp2", b_hp_p2, 0);
      chk("b_over", b_game_over, 1);
      chk("b_winner0", b_winner, 0);

      // P2 wins this one
      press_new();
      chk("b_ng_hp2", b_hp_p2, 5);
      press_atk(4'd0);
      press_atk(4'd9);
      chk("b_p2_hp1", b_hp_p1, 2);
      press_atk(4'd0);
      press_atk(4'd12);
      chk("b_p2_hp1_sat", b_hp_p1, 0);
      chk("b_p2_over", b_game_over, 1);
      chk("b_winner1", b_winner, 1);
      chk("b_p2_turn", b_turn, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/battle_turn_ctrl.md
Name: battle_turn_ctrl

Overview:
- Turn sequencer for the two-player battle datapath. Owns both players' HP registers and alternates attacks between P1 and P2.
- On each attack button press it samples the 4-bit GARO random word, decides hit/miss against a threshold, applies saturating damage to the defender, then passes the turn or declares a winner.
- Sits between the board keys and the GARO bank; its outputs drive the hex_display instances and the LEDs.

Parameters:
- W, 4, width of HP, damage and random word
- HP_INIT, 9, starting HP of each player
- DMG, 3, damage applied per hit
- HIT_THRESH, 7, a hit occurs when rand_in > HIT_THRESH (unsigned)
- SETTLE, 4, cycles spent in SAMPLE before latching rand_in (range 1..15)

Ports:
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-low reset
- key_attack_n  in  1  raw attack button, active-low, asynchronous to clk
- key_new_n  in  1  raw new-game button, active-low, asynchronous to clk
- rand_in  in  W  random word from the GARO bank
- rng_run  out  1  drives the GARO stop input; 1 lets the oscillators run
- hp_p1  out  W  player 1 HP
- hp_p2  out  W  player 2 HP
- turn  out  1  current attacker: 0 = P1, 1 = P2
- hit  out  1  result of the last resolved attack
- busy  out  1  high in SAMPLE, RESOLVE and CHECK
- game_over  out  1  high in OVER
- winner  out  1  valid when game_over is high; 0 = P1, 1 = P2

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, hp_p1=hp_p2=HP_INIT, turn=0, hit=0, winner=0, sample register=0, settle counter=0.
  - All synchronizer flops go to 1 (released key level).
  - Reset asserted mid-operation aborts the turn with no HP change after release.
- Input conditioning:
  - Each key passes through a 2-flop synchronizer plus a previous-value flop.
  - A press pulse is 1 cycle wide, on the sync 1→0 edge.
  - If a key goes low before rising edge k, its pulse is high between edges k+1 and k+2, so the FSM acts at edge k+2.
  - A held key produces exactly one pulse. No debounce; that is handled upstream.
- rng_run: 1 in every state except OVER, where it is 0 (freezes the GARO bank).
- FSM:
  - IDLE:
    - new-game pulse: HP reload to HP_INIT, turn=0, hit=0; stay in IDLE.
    - Otherwise attack pulse: counter=0, go to SAMPLE.
  - SAMPLE: counter increments each cycle. In the cycle where counter==SETTLE-1, rand_in is latched and the FSM goes to RESOLVE. Time in SAMPLE is exactly SETTLE cycles.
  - RESOLVE (1 cycle):
    - hit <= (sample > HIT_THRESH).
    - On a hit, the defender (hp_p2 if turn=0, else hp_p1) <= (hp >= DMG) ? hp-DMG : 0. Saturating; never wraps.
    - On a miss, HP is unchanged.
    - Go to CHECK.
  - CHECK (1 cycle):
    - If the defender HP==0: winner<=turn, go to OVER.
    - Else: turn<=~turn, go to IDLE.
  - OVER: ignores attack. A new-game pulse reloads both HPs, sets turn=0, hit=0, winner=0, and goes to IDLE.
- Total latency, IDLE exit to back in IDLE: SETTLE+2 cycles.
- Attack or new-game pulses while busy=1 are dropped, not queued.
- Simultaneous attack and new-game pulses:
  - In IDLE, new-game wins.
  - In OVER, only new-game is acted on.
- hit holds its value until the next RESOLVE or a new game.

Test Plan:
- Reset then idle → hp_p1=9, hp_p2=9, turn=0, busy=0, game_over=0, rng_run=1.
- rand_in=8, one attack press → busy rises at edge k+2; hp_p2=6 and hit=1 one cycle after SAMPLE ends (SETTLE=4); turn=1 the following cycle; busy low after 6 cycles total.
- rand_in=7, attack → hit=0, both HPs stay 9, turn toggles to 1 (boundary of the threshold).
- rand_in=15, P1 hits 3 times while P2 always gets rand_in=0:
  - hp_p2 goes 9→6→3→0; hp_p1 stays 9.
  - game_over=1, winner=0, rng_run=0.
  - Further attacks are ignored; a new-game press gives 9/9, turn=0.
- HP_INIT=5, DMG=3 with continuous hits → defender 5→2→0 (saturates, no wrap to 15); a second attack press during SAMPLE is dropped.
- Reset asserted in SAMPLE → immediate return to IDLE with hp 9/9 and turn=0.
- Attack and new-game pressed in the same cycle from IDLE → HP reloaded, no turn executed.
